// File: rtl/gpu_pkg.sv
// Shared GPU definitions: pattern modes, writer FSM states and the default
// pixel/coordinate widths that the GPU pixel-write port also uses.
package gpu_pkg;

    localparam int unsigned GPU_COORD_W = 6;
    localparam int unsigned GPU_PX_W    = 8;
    localparam int unsigned FRAME_CNT_W = 16;

    typedef enum logic [1:0] {
        MODE_BLINK = 2'd0,
        MODE_CYCLE = 2'd1,
        MODE_MOVE  = 2'd2,
        MODE_CHECK = 2'd3
    } mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DRAW = 1'b1
    } state_e;

    // Counter width able to hold 0..n-1; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/gpu_pattern_timer.sv
// Frame period counter for the pattern writer.
// Counts 0..PERIOD_CYCLES-1 while i_en is high, holds while low, and wraps to
// zero on terminal count. i_clr forces zero and takes priority.
// Ports:
//   clk, rstn   clock, asynchronous active-low reset
//   i_en        count enable
//   i_clr       synchronous clear
//   o_tc_c      terminal count (counter == PERIOD_CYCLES-1), combinational
module gpu_pattern_timer
    import gpu_pkg::*;
#(
    parameter int unsigned PERIOD_CYCLES = 8388608
) (
    input  logic clk,
    input  logic rstn,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tc_c
);

    localparam int unsigned         CNT_W = cnt_width(PERIOD_CYCLES);
    localparam logic [CNT_W-1:0]    TC    = CNT_W'(PERIOD_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_tc_c = (r_cnt == TC);

    // Period counter
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= o_tc_c ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/gpu_pattern_writer.sv
// Test-pattern source: every PERIOD_CYCLES enabled idle cycles it draws a
// RECT_W x RECT_H block into the GPU frame buffer in raster order, one pixel
// per accepted cycle, honouring gpu_busy back-pressure.
// Modes (latched at frame start): blink, colour-cycle, moving-box, checker.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   enable             run request, only looked at while idle
//   mode               pattern mode, latched when a frame starts
//   gpu_busy           GPU cannot take a pixel this cycle
//   write              pixel write strobe
//   px_data            pixel value
//   column, row        pixel coordinate, wraps modulo 2^COORD_W
//   image_palette      frame parity, drives GPU palette select
//   led                copy of image_palette
// Build option GPU_PATTERN_FRAME_COUNT_EN adds:
//   frame_count        completed frames, 16-bit wrapping
//   busy_stall         a write was stalled by gpu_busy in the previous cycle
module gpu_pattern_writer
    import gpu_pkg::*;
#(
    parameter int unsigned    COORD_W       = GPU_COORD_W,
    parameter int unsigned    PX_W          = GPU_PX_W,
    parameter int unsigned    RECT_W        = 2,
    parameter int unsigned    RECT_H        = 2,
    parameter int unsigned    ORIGIN_X      = 15,
    parameter int unsigned    ORIGIN_Y      = 0,
    parameter int unsigned    PERIOD_CYCLES = 8388608,
    parameter logic [PX_W-1:0] COLOR_A      = PX_W'(8'h01),
    parameter logic [PX_W-1:0] COLOR_B      = PX_W'(8'h00)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               gpu_busy,
    output logic               write,
    output logic [PX_W-1:0]    px_data,
    output logic [COORD_W-1:0] column,
    output logic [COORD_W-1:0] row,
    output logic               image_palette,
    output logic               led
`ifdef GPU_PATTERN_FRAME_COUNT_EN
    ,
    output logic [FRAME_CNT_W-1:0] frame_count,
    output logic                   busy_stall
`endif
);

    localparam logic [COORD_W-1:0] DX_LAST = COORD_W'(RECT_W - 1);
    localparam logic [COORD_W-1:0] DY_LAST = COORD_W'(RECT_H - 1);
    localparam logic [COORD_W-1:0] ORG_X0  = COORD_W'(ORIGIN_X);
    localparam logic [COORD_W-1:0] ORG_Y   = COORD_W'(ORIGIN_Y);

    state_e             r_state, w_state_nxt;
    mode_e              r_mode, w_mode_nxt;
    logic [COORD_W-1:0] r_dx, w_dx_nxt;
    logic [COORD_W-1:0] r_dy, w_dy_nxt;
    logic [COORD_W-1:0] r_org_x, w_org_x_nxt;
    logic [PX_W-1:0]    r_cyc, w_cyc_nxt;
    logic               r_frame, w_frame_nxt;
    logic               r_write, w_write_nxt;
    logic [PX_W-1:0]    r_px, w_px_nxt;
    logic [COORD_W-1:0] r_col, w_col_nxt;
    logic [COORD_W-1:0] r_row, w_row_nxt;

    logic               w_tc;
    logic               w_timer_en;
    logic               w_frame_done;
    logic               w_accept;
    logic               w_last;
    logic [COORD_W-1:0] w_dx_adv;
    logic [COORD_W-1:0] w_dy_adv;

    // Pixel value for raster offset (dx,dy) under mode m with frame parity f.
    function automatic logic [PX_W-1:0] f_pixel(
        input mode_e              m,
        input logic [COORD_W-1:0] dx,
        input logic [COORD_W-1:0] dy,
        input logic               f,
        input logic [PX_W-1:0]    cyc
    );
        logic [PX_W-1:0] v;
        case (m)
            MODE_BLINK: v = f ? COLOR_B : COLOR_A;
            MODE_CYCLE: v = cyc;
            MODE_MOVE:  v = COLOR_A;
            MODE_CHECK: v = (dx[0] ^ dy[0] ^ f) ? COLOR_B : COLOR_A;
            default:    v = COLOR_A;
        endcase
        return v;
    endfunction

    // Idle period timer; runs only in IDLE with enable, cleared at frame end.
    assign w_timer_en = (r_state == ST_IDLE) && enable;

    gpu_pattern_timer #(
        .PERIOD_CYCLES(PERIOD_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rstn   (rstn),
        .i_en   (w_timer_en),
        .i_clr  (w_frame_done),
        .o_tc_c (w_tc)
    );

    // Next-state, raster walk and pixel load
    always_comb begin
        w_state_nxt  = r_state;
        w_mode_nxt   = r_mode;
        w_dx_nxt     = r_dx;
        w_dy_nxt     = r_dy;
        w_org_x_nxt  = r_org_x;
        w_cyc_nxt    = r_cyc;
        w_frame_nxt  = r_frame;
        w_write_nxt  = r_write;
        w_px_nxt     = r_px;
        w_col_nxt    = r_col;
        w_row_nxt    = r_row;
        w_frame_done = 1'b0;

        w_accept = (r_state == ST_DRAW) && r_write && !gpu_busy;
        w_last   = (r_dx == DX_LAST) && (r_dy == DY_LAST);
        w_dx_adv = (r_dx == DX_LAST) ? '0 : r_dx + COORD_W'(1);
        w_dy_adv = (r_dx == DX_LAST) ? r_dy + COORD_W'(1) : r_dy;

        case (r_state)
            ST_IDLE: begin
                if (enable && w_tc) begin
                    w_state_nxt = ST_DRAW;
                    w_mode_nxt  = mode_e'(mode);
                    w_dx_nxt    = '0;
                    w_dy_nxt    = '0;
                    w_write_nxt = 1'b1;
                    w_px_nxt    = f_pixel(mode_e'(mode), '0, '0, r_frame, r_cyc);
                    w_col_nxt   = r_org_x;
                    w_row_nxt   = ORG_Y;
                end
            end
            ST_DRAW: begin
                if (w_accept) begin
                    if (w_last) begin
                        w_state_nxt  = ST_IDLE;
                        w_write_nxt  = 1'b0;
                        w_frame_nxt  = !r_frame;
                        w_frame_done = 1'b1;
                        // Only the latched mode's per-frame state moves.
                        case (r_mode)
                            MODE_CYCLE: w_cyc_nxt   = r_cyc + PX_W'(1);
                            MODE_MOVE:  w_org_x_nxt = r_org_x + COORD_W'(1);
                            default:    ;
                        endcase
                    end else begin
                        w_dx_nxt  = w_dx_adv;
                        w_dy_nxt  = w_dy_adv;
                        w_px_nxt  = f_pixel(r_mode, w_dx_adv, w_dy_adv, r_frame, r_cyc);
                        w_col_nxt = r_org_x + w_dx_adv;
                        w_row_nxt = ORG_Y + w_dy_adv;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_mode  <= MODE_BLINK;
            r_dx    <= '0;
            r_dy    <= '0;
            r_org_x <= ORG_X0;
            r_cyc   <= COLOR_A;
            r_frame <= 1'b0;
            r_write <= 1'b0;
            r_px    <= '0;
            r_col   <= '0;
            r_row   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_mode  <= w_mode_nxt;
            r_dx    <= w_dx_nxt;
            r_dy    <= w_dy_nxt;
            r_org_x <= w_org_x_nxt;
            r_cyc   <= w_cyc_nxt;
            r_frame <= w_frame_nxt;
            r_write <= w_write_nxt;
            r_px    <= w_px_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
        end
    end

    assign write         = r_write;
    assign px_data       = r_px;
    assign column        = r_col;
    assign row           = r_row;
    assign image_palette = r_frame;
    assign led           = r_frame;

`ifdef GPU_PATTERN_FRAME_COUNT_EN
    logic [FRAME_CNT_W-1:0] r_frame_cnt;
    logic                   r_busy_stall;

    // Completed-frame counter and stall flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_frame_cnt  <= '0;
            r_busy_stall <= 1'b0;
        end else begin
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + FRAME_CNT_W'(1);
            end
            r_busy_stall <= (r_state == ST_DRAW) && r_write && gpu_busy;
        end
    end

    assign frame_count = r_frame_cnt;
    assign busy_stall  = r_busy_stall;
`endif

endmodule

// File: tb/tb_gpu_pattern_writer.sv
// Self-checking bench for gpu_pattern_writer: directed scenarios followed by
// randomized enable/mode/back-pressure/reset, all compared every cycle against
// a frame-level reference model (timer count, pixel index, frame parity).
module tb_gpu_pattern_writer;

    localparam int unsigned COORD_W = 6;
    localparam int unsigned PX_W    = 8;
    localparam int          RW      = 2;
    localparam int          RH      = 2;
    localparam int          OX      = 15;
    localparam int          OY      = 0;
    localparam int          PER     = 8;
    localparam int          CA      = 8'h01;
    localparam int          CB      = 8'h00;
    localparam int          SCR     = 1 << COORD_W;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               enable = 1'b0;
    logic [1:0]         mode = 2'd0;
    logic               gpu_busy = 1'b0;
    logic               write;
    logic [PX_W-1:0]    px_data;
    logic [COORD_W-1:0] column;
    logic [COORD_W-1:0] row;
    logic               image_palette;
    logic               led;
`ifdef GPU_PATTERN_FRAME_COUNT_EN
    logic [15:0]        frame_count;
    logic               busy_stall;
`endif

    gpu_pattern_writer #(
        .COORD_W       (COORD_W),
        .PX_W          (PX_W),
        .RECT_W        (RW),
        .RECT_H        (RH),
        .ORIGIN_X      (OX),
        .ORIGIN_Y      (OY),
        .PERIOD_CYCLES (PER),
        .COLOR_A       (8'h01),
        .COLOR_B       (8'h00)
    ) dut (
        .clk           (clk),
        .rstn          (rstn),
        .enable        (enable),
        .mode          (mode),
        .gpu_busy      (gpu_busy),
        .write         (write),
        .px_data       (px_data),
        .column        (column),
        .row           (row),
        .image_palette (image_palette),
        .led           (led)
`ifdef GPU_PATTERN_FRAME_COUNT_EN
        ,
        .frame_count   (frame_count),
        .busy_stall    (busy_stall)
`endif
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state
    int m_timer, m_k, m_mode, m_frame, m_ox, m_cyc, m_fc;
    bit m_draw, m_stall;
    int e_px, e_col, e_row;

    // Accepted-pixel log
    int acc_col[$];
    int acc_row[$];
    int acc_px[$];

    function automatic int model_pixel(input int md, input int k, input int f);
        int dx, dy;
        dx = k % RW;
        dy = k / RW;
        case (md)
            0:       return (f != 0) ? CB : CA;
            1:       return m_cyc;
            2:       return CA;
            default: return (((dx ^ dy ^ f) & 1) != 0) ? CB : CA;
        endcase
    endfunction

    task automatic model_reset();
        m_timer = 0; m_k = 0; m_mode = 0; m_frame = 0; m_ox = OX; m_cyc = CA;
        m_fc = 0; m_draw = 0; m_stall = 0;
        e_px = 0; e_col = 0; e_row = 0;
    endtask

    task automatic model_edge(input bit en, input int md, input bit busy);
        m_stall = m_draw && busy;
        if (!m_draw) begin
            if (en) begin
                if (m_timer == PER - 1) begin
                    m_draw = 1; m_mode = md; m_k = 0; m_timer = 0;
                end else begin
                    m_timer++;
                end
            end
        end else if (!busy) begin
            if (m_k == RW * RH - 1) begin
                m_draw = 0; m_timer = 0;
                if (m_mode == 1) m_cyc = (m_cyc + 1) % 256;
                if (m_mode == 2) m_ox = (m_ox + 1) % SCR;
                m_frame ^= 1;
                m_fc = (m_fc + 1) % 65536;
            end else begin
                m_k++;
            end
        end
        if (m_draw) begin
            e_px  = model_pixel(m_mode, m_k, m_frame);
            e_col = (m_ox + m_k % RW) % SCR;
            e_row = (OY + m_k / RW) % SCR;
        end
    endtask

    task automatic compare_all();
        check("write", write, m_draw);
        check("px_data", px_data, e_px);
        check("column", column, e_col);
        check("row", row, e_row);
        check("image_palette", image_palette, m_frame);
        check("led", led, m_frame);
`ifdef GPU_PATTERN_FRAME_COUNT_EN
        check("frame_count", frame_count, m_fc);
        check("busy_stall", busy_stall, m_stall);
`endif
    endtask

    // One clock: called at a negedge, drives inputs, advances the model at
    // the posedge, compares at the following negedge.
    task automatic step(input bit en, input int md, input bit busy);
        if (write && !busy) begin
            acc_col.push_back(int'(column));
            acc_row.push_back(int'(row));
            acc_px.push_back(int'(px_data));
        end
        enable   = en;
        mode     = 2'(md);
        gpu_busy = busy;
        @(posedge clk);
        model_edge(en, md, busy);
        @(negedge clk);
        compare_all();
    endtask

    task automatic hard_reset();
        rstn = 1'b0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        compare_all();
    endtask

    task automatic reset_mid();
        #1 rstn = 1'b0;
        #1 check("async_reset_write", write, 0);
        model_reset();
        @(negedge clk);
        rstn = 1'b1;
        compare_all();
    endtask

    task automatic clear_log();
        acc_col.delete();
        acc_row.delete();
        acc_px.delete();
    endtask

    int  rise;
    int  guard;
    bit  pal_seen;
    int  exp_col[4] = '{15, 16, 15, 16};
    int  exp_row[4] = '{0, 0, 1, 1};

    initial begin
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        compare_all();

        // Blink: first write timing, raster order, colours of two frames
        rise = -1;
        for (int i = 1; i <= 12; i++) begin
            step(1, 0, 0);
            if (rise < 0 && write) rise = i;
        end
        check("first_write_edge", rise, PER);
        guard = 0;
        pal_seen = 0;
        while (acc_px.size() < 8 && guard < 60) begin
            step(1, 0, 0);
            pal_seen |= image_palette;
            guard++;
        end
        check("two_frames_done", acc_px.size() >= 8, 1);
        check("palette_rose", pal_seen, 1);
        if (acc_px.size() >= 8) begin
            for (int i = 0; i < 4; i++) begin
                check("f1_col", acc_col[i], exp_col[i]);
                check("f1_row", acc_row[i], exp_row[i]);
                check("f1_px", acc_px[i], 8'h01);
                check("f2_px", acc_px[i + 4], 8'h00);
            end
        end

        // Back-pressure on the second pixel
        hard_reset();
        clear_log();
        guard = 0;
        while (!write && guard < 20) begin step(1, 0, 0); guard++; end
        check("stall_frame_start", write, 1);
        step(1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, 1);
            check("stall_hold_col", column, 16);
            check("stall_hold_row", row, 0);
            check("stall_hold_write", write, 1);
        end
        guard = 0;
        while (write && guard < 20) begin step(1, 0, 0); guard++; end
        check("stall_accepted", acc_px.size(), 4);

        // Moving box long enough for the origin to wrap past column 63
        repeat (700) step(1, 2, 0);

        // Mode change in the middle of a blink frame
        guard = 0;
        while (!write && guard < 20) begin step(1, 0, 0); guard++; end
        repeat (30) step(1, 3, 0);

        // Asynchronous reset mid-frame
        guard = 0;
        while (!write && guard < 20) begin step(1, 0, 0); guard++; end
        step(1, 0, 0);
        reset_mid();
        clear_log();
        repeat (5) step(1, 0, 0);
        check("no_write_after_reset", acc_px.size(), 0);

        // Enable low freezes the timer and suppresses writes
        clear_log();
        repeat (30) step(0, 1, 0);
        check("no_write_disabled", acc_px.size(), 0);
        repeat (20) step(1, 1, 0);

`ifdef GPU_PATTERN_FRAME_COUNT_EN
        hard_reset();
        repeat (3 * (PER + RW * RH)) step(1, 0, 0);
        check("frame_count_3", frame_count, 3);
`endif

        // Randomized enable, mode, back-pressure and mid-frame reset
        for (int i = 0; i < 3000; i++) begin
            if (m_draw && ($urandom % 150) == 0) begin
                reset_mid();
            end else begin
                step(($urandom % 10) != 0, int'($urandom % 4), ($urandom % 3) == 0);
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
